mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one memory port (addr/rmask/wmask/rdata/wdata/resp) between two requesters.
//  Requesters are the instruction-fetch port (I) and the load/store port (D).
//  Captures each requester's one-cycle request pulse and issues one request at a time downstream.
//  Returns rdata/resp to the originating requester.
//  Sits between the core's fetch/LSU and the memory model or cache.
// PARAMETERS
//  none (all widths fixed: addr 32, data 32, mask 4)
// PORTS
//  clk        in   1   clock; only clock domain
//  rst        in   1   reset, synchronous, active-high
//  i_addr     in   32  I request address
//  i_rmask    in   4   I read mask; nonzero for 1 cycle = read request
//  i_rdata    out  32  I read data, valid when i_resp=1
//  i_resp     out  1   I response pulse (1 cycle)
//  d_addr     in   32  D request address
//  d_rmask    in   4   D read mask; nonzero = read request
//  d_wmask    in   4   D write mask; nonzero = write request
//  d_wdata    in   32  D write data
//  d_rdata    out  32  D read data, valid when d_resp=1
//  d_resp     out  1   D response pulse (1 cycle)
//  mem_addr   out  32  downstream address
//  mem_rmask  out  4   downstream read mask (1-cycle pulse)
//  mem_wmask  out  4   downstream write mask (1-cycle pulse)
//  mem_wdata  out  32  downstream write data
//  mem_rdata  in   32  downstream read data
//  mem_resp   in   1   downstream response pulse
//  proto_err  out  1   sticky protocol-violation flag
// BEHAVIOUR
//  - Reset: all outputs 0, both pending slots empty, FSM=IDLE, last_grant=D, proto_err=0.
//  - Request pulse semantics:
//    - a port's request is any cycle with its rmask|wmask != 0;
//    - the whole request is latched that cycle into the port's 1-entry pending slot (addr, masks, wdata);
//    - requester inputs are don't-care afterwards.
//  - At most one outstanding request per port.
//    - A new request while that port's slot is full or in flight sets proto_err;
//    - the offending request is dropped and the existing request is kept.
//  - D request with both rmask and wmask nonzero: sets proto_err, request treated as write only.
//  - FSM IDLE -> ISSUE_I or ISSUE_D when a slot is full at a clock edge; the slot captured this cycle counts.
//    - ISSUE_x lasts exactly 1 cycle;
//    - mem_addr/mem_rmask/mem_wmask/mem_wdata are driven registered from slot x;
//    - all masks are 0 in every other state.
//  - ISSUE_x -> WAIT_x. mem_addr and mem_wdata hold in WAIT; masks return to 0.
//  - WAIT_x stays until mem_resp=1.
//    - On that edge, rdata is latched and x_resp pulses for 1 cycle the next cycle; slot x is freed.
//    - FSM goes to ISSUE_y if the other slot is full, else IDLE (back-to-back, no idle bubble).
//  - Latency: request at cycle N, idle memory -> mem mask at N+1; mem_resp at M -> x_resp at M+1.
//  - i_rdata/d_rdata hold last returned value; only the owner sees resp.
//  - mem_resp in IDLE/ISSUE: ignored, sets proto_err.
//  - Simultaneous I and D requests with both slots empty: arbitration rule (see CONFIGURATION).
//  - The response freeing slot x and a new request on port x in the same cycle:
//    - legal: x_resp is seen at M+1, so a request at M+1 or later is accepted;
//    - a request at M itself is a violation.
//  - rst mid-transaction: FSM and slots cleared, in-flight request abandoned, no resp emitted.
//    - A late mem_resp after reset sets proto_err.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN:
//    - defined: when both slots are full at a grant point, grant the port not equal to last_grant;
//      last_grant updates on each ISSUE.
//    - undefined: fixed priority, D always wins over I; last_grant is unused (no register).
//  Both modes: a lone waiting requester is granted immediately.
// TESTING
//  1. I read 0x1000 pulse, mem_resp 3 cycles after issue with rdata 0xDEADBEEF
//     -> mem_rmask=0xF at N+1; i_resp and i_rdata=0xDEADBEEF one cycle after mem_resp; d_resp stays 0.
//  2. D write 0x2004, wmask 0x3, wdata 0x0000ABCD -> mem_wmask=0x3 and mem_wdata=0x0000ABCD for 1 cycle;
//     d_resp after mem_resp; mem_rmask=0 throughout.
//  3. I read 0x0 and D read 0x40 in the same cycle -> D issued first, I issued the cycle after D's mem_resp;
//     with ARB_ROUND_ROBIN_EN and last_grant=D, I is issued first.
//  4. Second I request while first in WAIT -> proto_err=1 and stays set;
//     only one downstream request; the first completes normally.
//  5. rst asserted during WAIT_D -> outputs 0 next cycle, no d_resp;
//     mem_resp arriving after reset -> proto_err=1.
//  6. 100 random legal interleaved I/D requests, random resp delays 1-8
//     -> every request gets exactly one resp with correct rdata; no overlapping downstream masks.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one downstream memory port between the instruction-fetch port (I)
//   and the load/store port (D). Each port sends a one-cycle request pulse.
//   The pulse is captured into a 1-entry pending slot for that port. Requests
//   are issued downstream one at a time. rdata/resp are returned to the port
//   that owns the in-flight request.
//
//   Optional feature: define ARB_ROUND_ROBIN_EN to alternate grants when both
//   slots are full at a grant point. Without it, D has fixed priority over I.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   i_addr, i_rmask       I request (read only); a nonzero mask is a request pulse
//   i_rdata, i_resp       I response data and 1-cycle response pulse
//   d_addr, d_rmask,      D request; nonzero rmask means read, nonzero wmask means write
//   d_wmask, d_wdata
//   d_rdata, d_resp       D response data and 1-cycle response pulse
//   mem_addr, mem_rmask,  downstream request; the masks are 1-cycle pulses
//   mem_wmask, mem_wdata
//   mem_rdata, mem_resp   downstream response
//   proto_err             sticky protocol-violation flag
module mem_port_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_addr,
  input  logic [3:0]  i_rmask,
  output logic [31:0] i_rdata,
  output logic        i_resp,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_rmask,
  input  logic [3:0]  d_wmask,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_resp,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp,
  output logic        proto_err
);

  typedef enum logic [2:0] {IDLE, ISSUE_I, ISSUE_D, WAIT_I, WAIT_D} state_t;
  state_t state, state_nx;

  // Pending slots. A slot stays full from capture until its response edge,
  // so "full" also covers the in-flight case.
  logic        i_full;
  logic [31:0] i_slot_addr;
  logic [3:0]  i_slot_rmask;
  logic        d_full;
  logic [31:0] d_slot_addr;
  logic [3:0]  d_slot_rmask, d_slot_wmask;
  logic [31:0] d_slot_wdata;

  logic i_req, d_req, d_both, i_take, d_take, i_pend, d_pend;
  logic prefer_i;
  logic [31:0] i_eff_addr, d_eff_addr, d_eff_wdata;
  logic [3:0]  i_eff_rmask, d_eff_rmask, d_eff_wmask, d_in_rmask;

  always_comb begin
    i_req  = |i_rmask;
    d_req  = (|d_rmask) || (|d_wmask);
    d_both = (|d_rmask) && (|d_wmask);
    i_take = i_req && !i_full;
    d_take = d_req && !d_full;
    // Pending includes a request captured this cycle. This lets an idle
    // arbiter issue on the very next edge without a bubble.
    i_pend = i_full || i_take;
    d_pend = d_full || d_take;
    // A D request with both masks set is treated as a write only.
    d_in_rmask  = (|d_wmask) ? 4'h0 : d_rmask;
    i_eff_addr  = i_full ? i_slot_addr  : i_addr;
    i_eff_rmask = i_full ? i_slot_rmask : i_rmask;
    d_eff_addr  = d_full ? d_slot_addr  : d_addr;
    d_eff_rmask = d_full ? d_slot_rmask : d_in_rmask;
    d_eff_wmask = d_full ? d_slot_wmask : d_wmask;
    d_eff_wdata = d_full ? d_slot_wdata : d_wdata;
  end

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_d;  // 1 means D was granted last
  always_comb prefer_i = last_grant_d;
`else
  always_comb prefer_i = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (d_pend && (!i_pend || !prefer_i)) state_nx = ISSUE_D;
        else if (i_pend)                      state_nx = ISSUE_I;
      end
      ISSUE_I: state_nx = WAIT_I;
      ISSUE_D: state_nx = WAIT_D;
      WAIT_I:  if (mem_resp) state_nx = d_pend ? ISSUE_D : IDLE;
      WAIT_D:  if (mem_resp) state_nx = i_pend ? ISSUE_I : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      i_full       <= 1'b0;
      i_slot_addr  <= '0;
      i_slot_rmask <= '0;
      d_full       <= 1'b0;
      d_slot_addr  <= '0;
      d_slot_rmask <= '0;
      d_slot_wmask <= '0;
      d_slot_wdata <= '0;
      mem_addr     <= '0;
      mem_rmask    <= '0;
      mem_wmask    <= '0;
      mem_wdata    <= '0;
      i_rdata      <= '0;
      i_resp       <= 1'b0;
      d_rdata      <= '0;
      d_resp       <= 1'b0;
      proto_err    <= 1'b0;
    end else begin
      state <= state_nx;

      // Slot capture. The free happens only while the slot is in flight,
      // and capture needs an empty slot, so the two never collide.
      if (i_take) begin
        i_full       <= 1'b1;
        i_slot_addr  <= i_addr;
        i_slot_rmask <= i_rmask;
      end else if (state == WAIT_I && mem_resp) begin
        i_full <= 1'b0;
      end
      if (d_take) begin
        d_full       <= 1'b1;
        d_slot_addr  <= d_addr;
        d_slot_rmask <= d_in_rmask;
        d_slot_wmask <= d_wmask;
        d_slot_wdata <= d_wdata;
      end else if (state == WAIT_D && mem_resp) begin
        d_full <= 1'b0;
      end

      // Downstream outputs are loaded on entry to ISSUE. The masks pulse for
      // that single cycle; addr and wdata hold afterwards.
      mem_rmask <= '0;
      mem_wmask <= '0;
      if (state_nx == ISSUE_I) begin
        mem_addr  <= i_eff_addr;
        mem_rmask <= i_eff_rmask;
        mem_wdata <= '0;
      end else if (state_nx == ISSUE_D) begin
        mem_addr  <= d_eff_addr;
        mem_rmask <= d_eff_rmask;
        mem_wmask <= d_eff_wmask;
        mem_wdata <= d_eff_wdata;
      end

      // Route the response to the owner of the in-flight request.
      i_resp <= (state == WAIT_I) && mem_resp;
      d_resp <= (state == WAIT_D) && mem_resp;
      if (state == WAIT_I && mem_resp) i_rdata <= mem_rdata;
      if (state == WAIT_D && mem_resp) d_rdata <= mem_rdata;

      // Errors: a request to an occupied port, a D request with both masks
      // set, or a response that arrives while nothing is waiting.
      if ((i_req && i_full) || (d_req && d_full) || d_both ||
          (mem_resp && state != WAIT_I && state != WAIT_D))
        proto_err <= 1'b1;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (rst)                       last_grant_d <= 1'b1;
    else if (state_nx == ISSUE_I)  last_grant_d <= 1'b0;
    else if (state_nx == ISSUE_D)  last_grant_d <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter.
// Part 1 is a directed per-cycle vector table. Each record holds one cycle of
// inputs and the outputs expected just after that cycle's clock edge.
// Part 2 runs 100 random legal I/D requests against a small memory model and
// a per-port scoreboard.
module tb_mem_port_arbiter;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam logic [31:0] K = 32'h5A5A_C3C3;

  logic        clk = 1'b0, rst;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  i_rmask, d_rmask, d_wmask, mem_rmask, mem_wmask;
  logic        i_resp, d_resp, mem_resp, proto_err;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_rmask(i_rmask), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_rmask(d_rmask), .d_wmask(d_wmask), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst; logic [3:0] irm; logic [31:0] ia;
    logic [3:0] drm, dwm; logic [31:0] da, dwd; logic mr; logic [31:0] mrd;
    logic [3:0] e_mrm, e_mwm; logic [31:0] e_ma, e_mwd;
    logic e_ir; logic [31:0] e_ird; logic e_dr; logic [31:0] e_drd; logic e_pe;
  } vec_t;

  vec_t vecs[$];
  int vectors = 0, miscompares = 0;

  task automatic add(input logic r, input logic [3:0] irm, input logic [31:0] ia,
                     input logic [3:0] drm, dwm, input logic [31:0] da, dwd,
                     input logic mr, input logic [31:0] mrd,
                     input logic [3:0] emrm, emwm, input logic [31:0] ema, emwd,
                     input logic eir, input logic [31:0] eird,
                     input logic edr, input logic [31:0] edrd, input logic epe);
    vec_t v;
    v.rst = r; v.irm = irm; v.ia = ia; v.drm = drm; v.dwm = dwm; v.da = da; v.dwd = dwd;
    v.mr = mr; v.mrd = mrd; v.e_mrm = emrm; v.e_mwm = emwm; v.e_ma = ema; v.e_mwd = emwd;
    v.e_ir = eir; v.e_ird = eird; v.e_dr = edr; v.e_drd = edrd; v.e_pe = epe;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_in();
    rst = 1'b0; i_rmask = '0; i_addr = '0; d_rmask = '0; d_wmask = '0;
    d_addr = '0; d_wdata = '0; mem_resp = 1'b0; mem_rdata = '0;
  endtask

  initial begin
    idle_in();
    // rst irm ia      drm dwm da     dwd   mr mrd         | mrm mwm ma   mwd  ir ird       dr drd      pe
    add(1, 0, 0,       0, 0, 0,       0,    0, 0,           0, 0, 0,      0,   0, 0,        0, 0,       0);
    // I read, response three cycles after issue
    add(0, 4'hF, 32'h1000, 0, 0, 0, 0,     0, 0,            4'hF, 0, 32'h1000, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0,       0, 0, 0,       0,    0, 0,           0, 0, 32'h1000, 0, 0, 0,  0, 0,       0);
    add(0, 0, 0,       0, 0, 0,       0,    0, 0,           0, 0, 32'h1000, 0, 0, 0,  0, 0,       0);
    add(0, 0, 0,       0, 0, 0,       0,    0, 0,           0, 0, 32'h1000, 0, 0, 0,  0, 0,       0);
    add(0, 0, 0,       0, 0, 0,       0,    1, 32'hDEADBEEF, 0, 0, 32'h1000, 0, 1, 32'hDEADBEEF, 0, 0, 0);
    add(0, 0, 0,       0, 0, 0,       0,    0, 0,           0, 0, 32'h1000, 0, 0, 32'hDEADBEEF, 0, 0, 0);
    // D write
    add(0, 0, 0, 0, 4'h3, 32'h2004, 32'hABCD, 0, 0,       0, 4'h3, 32'h2004, 32'hABCD, 0, 32'hDEADBEEF, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,                        0, 0, 32'h2004, 32'hABCD, 0, 32'hDEADBEEF, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 32'h11111111,             0, 0, 32'h2004, 32'hABCD, 0, 32'hDEADBEEF, 1, 32'h11111111, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,                        0, 0, 32'h2004, 32'hABCD, 0, 32'hDEADBEEF, 0, 32'h11111111, 0);
    // simultaneous I read 0x0 and D read 0x40
    add(0, 4'hF, 0, 4'hF, 0, 32'h40, 0, 0, 0,             4'hF, 0, RR ? 32'h0 : 32'h40, 0, 0, 32'hDEADBEEF, 0, 32'h11111111, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,                        0, 0, RR ? 32'h0 : 32'h40, 0, 0, 32'hDEADBEEF, 0, 32'h11111111, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D,             4'hF, 0, RR ? 32'h40 : 32'h0, 0, RR, RR ? 32'hCAFEF00D : 32'hDEADBEEF,
        !RR, RR ? 32'h11111111 : 32'hCAFEF00D, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,                        0, 0, RR ? 32'h40 : 32'h0, 0, 0, RR ? 32'hCAFEF00D : 32'hDEADBEEF,
        0, RR ? 32'h11111111 : 32'hCAFEF00D, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 32'h12345678,             0, 0, RR ? 32'h40 : 32'h0, 0, !RR, RR ? 32'hCAFEF00D : 32'h12345678,
        RR, RR ? 32'h12345678 : 32'hCAFEF00D, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0,                        0, 0, 0, 0, 0, 0, 0, 0, 0);
    // second I request while the first is waiting
    add(0, 4'hF, 32'h100, 0, 0, 0, 0, 0, 0,               4'hF, 0, 32'h100, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,                        0, 0, 32'h100, 0, 0, 0, 0, 0, 0);
    add(0, 4'hF, 32'h200, 0, 0, 0, 0, 0, 0,               0, 0, 32'h100, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,                        0, 0, 32'h100, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 32'hA5A5A5A5,             0, 0, 32'h100, 0, 1, 32'hA5A5A5A5, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,                        0, 0, 32'h100, 0, 0, 32'hA5A5A5A5, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0,                        0, 0, 0, 0, 0, 0, 0, 0, 0);
    // re-request at M+1 is legal; re-request at M is a violation
    add(0, 0, 0, 4'hF, 0, 32'h300, 0, 0, 0,               4'hF, 0, 32'h300, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,                        0, 0, 32'h300, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 32'h0BADF00D,             0, 0, 32'h300, 0, 0, 0, 1, 32'h0BADF00D, 0);
    add(0, 0, 0, 4'hF, 0, 32'h400, 0, 0, 0,               4'hF, 0, 32'h400, 0, 0, 0, 0, 32'h0BADF00D, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,                        0, 0, 32'h400, 0, 0, 0, 0, 32'h0BADF00D, 0);
    add(0, 0, 0, 4'hF, 0, 32'h500, 0, 1, 32'h77,          0, 0, 32'h400, 0, 0, 0, 1, 32'h77, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,                        0, 0, 32'h400, 0, 0, 0, 0, 32'h77, 1);
    // reset during WAIT_D, then a late response
    add(1, 0, 0, 0, 0, 0, 0, 0, 0,                        0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 4'hF, 32'h600, 32'h99, 0, 0,          0, 4'hF, 32'h600, 32'h99, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,                        0, 0, 32'h600, 32'h99, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0,                        0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,                        0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 32'h55,                   0, 0, 0, 0, 0, 0, 0, 0, 1);
    // D request with both masks set: error, issued as a write only
    add(1, 0, 0, 0, 0, 0, 0, 0, 0,                        0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 4'hF, 4'hF, 32'h700, 32'h42, 0, 0,       0, 4'hF, 32'h700, 32'h42, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0,                        0, 0, 32'h700, 32'h42, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 32'h13,                   0, 0, 32'h700, 32'h42, 0, 0, 1, 32'h13, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0,                        0, 0, 0, 0, 0, 0, 0, 0, 0);

    foreach (vecs[k]) begin
      rst = vecs[k].rst; i_rmask = vecs[k].irm; i_addr = vecs[k].ia;
      d_rmask = vecs[k].drm; d_wmask = vecs[k].dwm; d_addr = vecs[k].da; d_wdata = vecs[k].dwd;
      mem_resp = vecs[k].mr; mem_rdata = vecs[k].mrd;
      @(posedge clk); #1;
      chk($sformatf("v%0d mem_rmask", k), {28'h0, mem_rmask}, {28'h0, vecs[k].e_mrm});
      chk($sformatf("v%0d mem_wmask", k), {28'h0, mem_wmask}, {28'h0, vecs[k].e_mwm});
      chk($sformatf("v%0d mem_addr", k),  mem_addr,  vecs[k].e_ma);
      chk($sformatf("v%0d mem_wdata", k), mem_wdata, vecs[k].e_mwd);
      chk($sformatf("v%0d i_resp", k),    {31'h0, i_resp}, {31'h0, vecs[k].e_ir});
      chk($sformatf("v%0d i_rdata", k),   i_rdata,   vecs[k].e_ird);
      chk($sformatf("v%0d d_resp", k),    {31'h0, d_resp}, {31'h0, vecs[k].e_dr});
      chk($sformatf("v%0d d_rdata", k),   d_rdata,   vecs[k].e_drd);
      chk($sformatf("v%0d proto_err", k), {31'h0, proto_err}, {31'h0, vecs[k].e_pe});
    end

    // Random legal traffic with a memory model that answers with addr ^ K.
    begin
      int issued = 0, resps = 0, cyc = 0, mem_cnt = 0;
      bit i_out = 0, d_out = 0, mem_busy = 0;
      logic [31:0] i_a = '0, d_a = '0;
      while ((issued < 100 || i_out || d_out) && cyc < 5000) begin
        idle_in();
        if (!i_out && issued < 100 && $urandom_range(0, 2) == 0) begin
          i_a = $urandom & 32'hFFFF_FFFC; i_addr = i_a; i_rmask = 4'hF;
          i_out = 1; issued++;
        end
        if (!d_out && issued < 100 && $urandom_range(0, 2) == 0) begin
          d_a = $urandom & 32'hFFFF_FFFC; d_addr = d_a; d_wdata = $urandom;
          if ($urandom_range(0, 1) == 1) d_wmask = 4'(($urandom_range(1, 15)));
          else                           d_rmask = 4'hF;
          d_out = 1; issued++;
        end
        if (mem_busy) begin
          if (mem_cnt == 0) begin
            mem_resp = 1'b1; mem_rdata = mem_addr ^ K; mem_busy = 0;
          end else mem_cnt--;
        end
        @(posedge clk); #1;
        cyc++;
        if (mem_rmask != 0 || mem_wmask != 0) begin
          chk("rand overlap", {31'h0, mem_busy}, 32'h0);
          chk("rand masks exclusive", {31'h0, mem_rmask != 0 && mem_wmask != 0}, 32'h0);
          mem_busy = 1; mem_cnt = $urandom_range(1, 8);
        end
        if (i_resp) begin
          chk("rand i_resp owner", {31'h0, i_out}, 32'h1);
          chk("rand i_rdata", i_rdata, i_a ^ K);
          i_out = 0; resps++;
        end
        if (d_resp) begin
          chk("rand d_resp owner", {31'h0, d_out}, 32'h1);
          chk("rand d_rdata", d_rdata, d_a ^ K);
          d_out = 0; resps++;
        end
      end
      chk("rand all responded", resps, 100);
      chk("rand proto_err", {31'h0, proto_err}, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
